dsm_sample_sched: RTL and testbench

Sample scheduler for the delta-sigma modulator: accepts 15-bit signed samples from the upstream interpolator over a valid/ready handshake, buffers them in a small FIFO, and issues one sample to `dsm_top.vin` every `osr` clock cycles. It replaces the free-running slow-clock sample feed, so the whole modulator path runs on the single fast `clock`. It also handles priming, underflow and enable/disable sequencing.

---
 rtl/dsm_pkg.sv | 6 +
 rtl/dsm_sample_fifo.sv | 41 ++++
 rtl/dsm_sample_sched.sv | 63 ++++++
 tb/tb_dsm_sample_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// dsm_pkg: shared types and widths for the delta-sigma modulator path
package dsm_pkg;
  localparam int DSM_DATA_W = 15;
  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;
  typedef enum logic [1:0] {PWM_ZERO = 2'b00, PWM_POS = 2'b01, PWM_NEG = 2'b11} pwm_t;
endpackage

// File: rtl/dsm_sample_fifo.sv
// dsm_sample_fifo: synchronous sample FIFO with flush, extra-MSB wrap pointers
module dsm_sample_fifo #(
  parameter int DATA_W = 15,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign level   = wp - rp;
  assign full    = level == FULL_LVL;
  assign empty   = wp == rp;
  assign rdata   = mem[rp[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clock)
    if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/dsm_sample_sched.sv
// dsm_sample_sched: buffers upstream samples and issues one to the modulator every osr clocks
module dsm_sample_sched
  import dsm_pkg::*;
#(
  parameter int DATA_W    = DSM_DATA_W,
  parameter int OSR_W     = 8,
  parameter int DEPTH     = 4,
  parameter int PRIME_LVL = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [OSR_W-1:0]       osr,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      vin,
  output logic                   vin_strobe,
  output logic                   underflow,
  input  logic                   underflow_clr,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] level
);
  localparam logic [$clog2(DEPTH):0] PL = PRIME_LVL[$clog2(DEPTH):0];
  state_t st, st_nx;
  logic [OSR_W-1:0] cnt, osr_eff;
  logic [DATA_W-1:0] head;
  logic full, empty, push, pop, flush, tick, slot;
  assign state    = st;
  assign in_ready = st != IDLE && !full;
  assign push     = in_valid && in_ready;
  assign flush    = !enable || st == IDLE;
  assign tick     = cnt == osr_eff - 1'b1;
  assign slot     = enable && st == RUN && tick;
  assign pop      = slot && !empty;
  dsm_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .flush(flush),
    .wdata(in_data), .rdata(head), .full(full), .empty(empty), .level(level)
  );
  always_comb
    st_nx = !enable      ? IDLE :
            st == IDLE   ? PRIME :
            st == PRIME  ? (level >= PL ? RUN : PRIME) :
            st == RUN    ? (tick && empty ? PRIME : RUN) : IDLE;
  // osr is only sampled at period boundaries so a mid-period change never stretches the current slot
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      st         <= IDLE;
      cnt        <= '0;
      osr_eff    <= OSR_W'(1);
      vin        <= '0;
      vin_strobe <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      st         <= st_nx;
      vin_strobe <= slot;
      cnt        <= (st == RUN && st_nx == RUN && !tick) ? cnt + 1'b1 : '0;
      if ((st == PRIME && st_nx == RUN) || slot) osr_eff <= osr == '0 ? OSR_W'(1) : osr;
      if (flush) vin <= '0;
      else if (slot) vin <= empty ? '0 : head;
      underflow  <= (slot && empty) || (underflow && !underflow_clr);
    end
endmodule

// File: tb/tb_dsm_sample_sched.sv
// tb_dsm_sample_sched: directed checks of the sample scheduler
module tb_dsm_sample_sched;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  osr = '0;
  logic [14:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] vin;
  logic        vin_strobe;
  logic        underflow;
  logic        underflow_clr = 1'b0;
  logic [1:0]  state;
  logic [2:0]  level;
  int checks = 0;
  int failures = 0;

  dsm_sample_sched dut (
    .clock(clock), .reset(reset), .enable(enable), .osr(osr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .vin(vin), .vin_strobe(vin_strobe), .underflow(underflow),
    .underflow_clr(underflow_clr), .state(state), .level(level)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (vin !== 15'd0 || vin_strobe !== 1'b0) begin failures++; $display("FAIL reset_vin got=%0d/%0b exp=0/0", vin, vin_strobe); end
    checks++; if (in_ready !== 1'b0 || underflow !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL reset_misc got=%0b/%0b/%0d exp=0/0/0", in_ready, underflow, level); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [14:0] exp_v [3];
    exp_v[0] = 15'(100); exp_v[1] = 15'(-200); exp_v[2] = 15'(300);
    enable = 1'b1; osr = 8'd4;
    cyc();
    checks++; if (state !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL basic_prime got=%0d/%0b exp=1/1", state, in_ready); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = exp_v[i];
      cyc();
      if (i == 1) begin
        checks++; if (state !== 2'd1 || level !== 3'd2) begin failures++; $display("FAIL basic_prime2 got=%0d/%0d exp=1/2", state, level); end
      end
    end
    in_valid = 1'b0;
    checks++; if (state !== 2'd2 || level !== 3'd3) begin failures++; $display("FAIL basic_run got=%0d/%0d exp=2/3", state, level); end
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 3; k++) begin
        cyc();
        checks++; if (vin_strobe !== 1'b0) begin failures++; $display("FAIL basic_gap got=%0b exp=0 slot=%0d", vin_strobe, s); end
      end
      cyc();
      checks++; if (vin_strobe !== 1'b1 || vin !== exp_v[s]) begin failures++; $display("FAIL basic_issue got=%0b/%0d exp=1/%0d", vin_strobe, $signed(vin), $signed(exp_v[s])); end
    end
    enable = 1'b0;
    cyc();
    checks++; if (state !== 2'd0 || vin !== 15'd0 || vin_strobe !== 1'b0) begin failures++; $display("FAIL basic_off got=%0d/%0d/%0b exp=0/0/0", state, vin, vin_strobe); end
  endtask

  task automatic test_osr01();
    int nxt = 1, exp_n = 1;
    logic hs;
    enable = 1'b1; osr = 8'd0;
    cyc();
    for (int i = 0; i < 10 && state != 2'd2; i++) begin
      in_valid = 1'b1; in_data = 15'(nxt); hs = in_ready;
      cyc();
      if (hs) nxt++;
    end
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL osr01_run got=%0d exp=2", state); end
    for (int i = 0; i < 12; i++) begin
      if (i == 6) osr = 8'd1;
      in_data = 15'(nxt); hs = in_ready;
      cyc();
      if (hs) nxt++;
      checks++; if (vin_strobe !== 1'b1 || vin !== 15'(exp_n)) begin failures++; $display("FAIL osr01_issue got=%0b/%0d exp=1/%0d", vin_strobe, vin, exp_n); end
      exp_n++;
    end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL osr01_uf got=%0b exp=0", underflow); end
    enable = 1'b0; in_valid = 1'b0;
    cyc();
    checks++; if (state !== 2'd0 || level !== 3'd0) begin failures++; $display("FAIL osr01_off got=%0d/%0d exp=0/0", state, level); end
  endtask

  task automatic test_full();
    int nxt = 10;
    logic hs;
    bit seen = 0;
    enable = 1'b1; osr = 8'd255;
    cyc();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 15'(nxt); hs = in_ready;
      cyc();
      if (hs) nxt++;
    end
    checks++; if (level !== 3'd4 || in_ready !== 1'b0 || nxt != 14) begin failures++; $display("FAIL full_hold got=%0d/%0b/%0d exp=4/0/14", level, in_ready, nxt); end
    in_valid = 1'b0; osr = 8'd1;
    for (int i = 0; i < 300 && !seen; i++) begin
      cyc();
      seen = vin_strobe;
    end
    checks++; if (!seen || vin !== 15'd10) begin failures++; $display("FAIL full_first got=%0b/%0d exp=1/10", seen, vin); end
    for (int k = 11; k < 14; k++) begin
      cyc();
      checks++; if (vin_strobe !== 1'b1 || vin !== 15'(k)) begin failures++; $display("FAIL full_drain got=%0b/%0d exp=1/%0d", vin_strobe, vin, k); end
    end
    enable = 1'b0;
    cyc();
    checks++; if (underflow !== 1'b0 || vin_strobe !== 1'b0 || state !== 2'd0) begin failures++; $display("FAIL full_off got=%0b/%0b/%0d exp=0/0/0", underflow, vin_strobe, state); end
  endtask

  task automatic test_underflow();
    logic [14:0] exp_v [4];
    exp_v[0] = 15'd7; exp_v[1] = 15'd8; exp_v[2] = 15'd9; exp_v[3] = 15'd0;
    enable = 1'b1; osr = 8'd2;
    cyc();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = exp_v[i];
      cyc();
    end
    in_valid = 1'b0;
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL uf_run got=%0d exp=2", state); end
    for (int t = 0; t < 4; t++) begin
      checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL uf_early got=%0b exp=0 slot=%0d", underflow, t); end
      cyc();
      checks++; if (vin_strobe !== 1'b0) begin failures++; $display("FAIL uf_gap got=%0b exp=0", vin_strobe); end
      cyc();
      checks++; if (vin_strobe !== 1'b1 || vin !== exp_v[t]) begin failures++; $display("FAIL uf_issue got=%0b/%0d exp=1/%0d", vin_strobe, vin, exp_v[t]); end
    end
    checks++; if (underflow !== 1'b1 || state !== 2'd1) begin failures++; $display("FAIL uf_set got=%0b/%0d exp=1/1", underflow, state); end
    underflow_clr = 1'b1;
    cyc();
    underflow_clr = 1'b0;
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL uf_clr got=%0b exp=0", underflow); end
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 15'(20 + i);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL uf_rerun got=%0d exp=2", state); end
    for (int t = 0; t < 2; t++) begin
      cyc();
      cyc();
      checks++; if (vin_strobe !== 1'b1 || vin !== 15'(20 + t)) begin failures++; $display("FAIL uf_reissue got=%0b/%0d exp=1/%0d", vin_strobe, vin, 20 + t); end
    end
    cyc();
    underflow_clr = 1'b1;
    cyc();
    underflow_clr = 1'b0;
    checks++; if (underflow !== 1'b1 || vin_strobe !== 1'b1 || vin !== 15'd0 || state !== 2'd1) begin failures++; $display("FAIL uf_setwins got=%0b/%0b/%0d/%0d exp=1/1/0/1", underflow, vin_strobe, vin, state); end
    underflow_clr = 1'b1; enable = 1'b0;
    cyc();
    underflow_clr = 1'b0;
  endtask

  task automatic test_disable();
    enable = 1'b1; osr = 8'd4;
    cyc();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 15'(40 + i);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    checks++; if (vin_strobe !== 1'b1 || vin !== 15'd40 || level !== 3'd3 || state !== 2'd2) begin failures++; $display("FAIL dis_pre got=%0b/%0d/%0d/%0d exp=1/40/3/2", vin_strobe, vin, level, state); end
    enable = 1'b0;
    cyc();
    checks++; if (state !== 2'd0 || level !== 3'd0 || vin !== 15'd0 || vin_strobe !== 1'b0) begin failures++; $display("FAIL dis_off got=%0d/%0d/%0d/%0b exp=0/0/0/0", state, level, vin, vin_strobe); end
    enable = 1'b1;
    cyc();
    checks++; if (state !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL dis_reprime got=%0d/%0b exp=1/1", state, in_ready); end
  endtask

  task automatic test_osr_change_and_reset();
    int n = 0;
    osr = 8'd3;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 15'(50 + i);
      cyc();
    end
    in_valid = 1'b0; osr = 8'd5;
    cyc();
    checks++; if (vin_strobe !== 1'b0) begin failures++; $display("FAIL osrchg_gap got=%0b exp=0", vin_strobe); end
    cyc();
    checks++; if (vin_strobe !== 1'b1 || vin !== 15'd50) begin failures++; $display("FAIL osrchg_old got=%0b/%0d exp=1/50", vin_strobe, vin); end
    do begin
      cyc();
      n++;
    end while (!vin_strobe && n < 10);
    checks++; if (n != 5 || vin !== 15'd51) begin failures++; $display("FAIL osrchg_new got=%0d/%0d exp=5/51", n, vin); end
    #3 reset = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || vin !== 15'd0 || vin_strobe !== 1'b0 || in_ready !== 1'b0 || level !== 3'd0 || underflow !== 1'b0) begin failures++; $display("FAIL async_reset got=%0d/%0d/%0b/%0b/%0d/%0b exp=0/0/0/0/0/0", state, vin, vin_strobe, in_ready, level, underflow); end
    enable = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_osr01();
    test_full();
    test_underflow();
    test_disable();
    test_osr_change_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
